bin_to_bcd: RTL and testbench

BIN_TO_BCD -- requirements
Module: bin_to_bcd

---
 rtl/ssd_pkg.sv | 45 ++++
 rtl/bin_to_bcd_if.sv | 35 +++
 rtl/bcd_add3.sv | 19 +
 rtl/bin_to_bcd.sv | 126 ++++++++++++
 tb/tb_bin_to_bcd.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg -- shared types for the seven-segment display path.
//
// Contents:
//   state_e       : FSM states of the binary-to-BCD converter
//   bcd_digit_t   : one BCD digit (4 bits)
//   BCD_NINE      : largest legal BCD digit value
//   BCD_ADD3_MIN  : smallest digit that gets the double-dabble +3 correction
//   seg7_t        : segment vector {g,f,e,d,c,b,a}, active-high
//   bcd_to_seg7() : display encoding of a BCD digit (blank for 10..15)
// ----------------------------------------------------------------------------
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE     = 4'd9;
    localparam bcd_digit_t BCD_ADD3_MIN = 4'd5;

    typedef logic [6:0] seg7_t;

    function automatic seg7_t bcd_to_seg7(input bcd_digit_t digit);
        seg7_t seg;
        case (digit)
            4'd0:    seg = 7'b011_1111;
            4'd1:    seg = 7'b000_0110;
            4'd2:    seg = 7'b101_1011;
            4'd3:    seg = 7'b100_1111;
            4'd4:    seg = 7'b110_0110;
            4'd5:    seg = 7'b110_1101;
            4'd6:    seg = 7'b111_1101;
            4'd7:    seg = 7'b000_0111;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b110_1111;
            default: seg = 7'b000_0000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_if -- request/result bundle of the binary-to-BCD converter.
//
// Signals:
//   i_start : conversion request (master -> slave)
//   i_bin   : unsigned binary value, BIN_W bits (master -> slave)
//   o_busy  : conversion in progress (slave -> master)
//   o_done  : one-cycle completion pulse (slave -> master)
//   o_bcd   : DIGITS packed BCD digits, MS digit in top nibble (slave -> master)
//   o_ovf   : value did not fit in DIGITS digits (slave -> master)
// Modports: master (requester), slave (converter).
// ----------------------------------------------------------------------------
interface bin_to_bcd_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) ();

    logic                  i_start;
    logic [BIN_W-1:0]      i_bin;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_ovf;

    modport master (
        output i_start, i_bin,
        input  o_busy, o_done, o_bcd, o_ovf
    );

    modport slave (
        input  i_start, i_bin,
        output o_busy, o_done, o_bcd, o_ovf
    );

endinterface

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3 -- combinational double-dabble digit correction.
//
// Ports:
//   digit_i : scratch digit before the shift
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i unchanged
// A digit >= 5 would become >= 10 after the left shift; adding 3 first makes
// the shift carry into the next digit instead.
// ----------------------------------------------------------------------------
module bcd_add3
    import ssd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= BCD_ADD3_MIN) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd.sv
// ----------------------------------------------------------------------------
// bin_to_bcd -- sequential binary-to-BCD converter (shift-and-add-3).
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : bin_to_bcd_if.slave (i_start, i_bin, o_busy, o_done, o_bcd, o_ovf)
// Parameters:
//   BIN_W  : binary input width
//   DIGITS : BCD output digits; legal only when 2^BIN_W-1 < 10^(DIGITS+1)
//
// One request is converted with BIN_W SHIFT cycles plus one DONE cycle; the
// result and o_done register on the DONE exit edge. A spare (DIGITS+1)th
// scratch digit catches values above 10^DIGITS-1 and drives o_ovf.
//
// Build option: BIN_TO_BCD_SAT_EN -- when defined, an overflowing result
// reads as all nines; when undefined, o_bcd carries the low DIGITS digits.
// ----------------------------------------------------------------------------
module bin_to_bcd
    import ssd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    bin_to_bcd_if.slave bus
);

    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int OUT_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [SCR_W-1:0]  scr_q, scr_d;
    logic [SCR_W-1:0]  scr_adj;
    logic [OUT_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              scr_ovf;

    // Per-digit +3 correction applied ahead of every shift.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scr_q[4*g +: 4]),
            .digit_o (scr_adj[4*g +: 4])
        );
    end

    assign scr_ovf = |scr_q[SCR_W-1 -: 4];

    // NOTE: every always_comb output gets a hold/idle default before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    bin_d   = bus.i_bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Corrected scratch and remaining binary shift as one word.
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ovf_d  = scr_ovf;
`ifdef BIN_TO_BCD_SAT_EN
                bcd_d  = scr_ovf ? {DIGITS{BCD_NINE}} : scr_q[OUT_W-1:0];
`else
                bcd_d  = scr_q[OUT_W-1:0];
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_busy = (state_q != IDLE);
    assign bus.o_done = done_q;
    assign bus.o_bcd  = bcd_q;
    assign bus.o_ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd -- self-checking bench for bin_to_bcd.
//
// An edge sampler decides which requests the converter must accept (one
// request per BIN_W+2 edges, none during reset) and pushes the expected
// result, computed with decimal arithmetic, with the edge it is due on.
// A monitor after every edge pops and compares, and otherwise checks that
// o_done stays low and the last result is held.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int OUT_W  = 4 * DIGITS;
    localparam int MAXV   = (1 << BIN_W) - 1;

    typedef struct {
        int               due;
        logic [OUT_W-1:0] bcd;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    bin_to_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               n_checks = 0;
    int               n_errors = 0;
    int               edge_cnt = 0;
    int               next_free = 0;
    exp_t             exp_q[$];
    logic [OUT_W-1:0] last_bcd = '0;
    logic             last_ovf = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, req);
        end
    endtask

    // Decimal reference: value split into digits with / and %.
    function automatic exp_t ref_model(input int value, input int due);
        exp_t r;
        int   lim = 1;
        int   m;
        for (int i = 0; i < DIGITS; i++) lim *= 10;
        r.ovf = (value >= lim);
        m     = value % lim;
`ifdef BIN_TO_BCD_SAT_EN
        if (r.ovf) m = lim - 1;
`endif
        r.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        r.due = due;
        return r;
    endfunction

    // Edge sampler: decides acceptance from the bench's own drive values.
    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n) begin
            next_free = edge_cnt + 1;
        end else if (bus.i_start && edge_cnt >= next_free) begin
            exp_q.push_back(ref_model(int'(bus.i_bin), edge_cnt + BIN_W + 1));
            next_free = edge_cnt + BIN_W + 2;
        end
    end

    // Reset aborts everything in flight and clears the held result.
    always @(negedge rst_n) begin
        exp_q.delete();
        last_bcd  = '0;
        last_ovf  = 1'b0;
        next_free = edge_cnt + 1;
    end

    // Monitor, one time unit after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        check("busy", 32'(bus.o_busy), 32'(edge_cnt <= next_free - 2));
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            e = exp_q.pop_front();
            check("done_pulse", 32'(bus.o_done), 32'd1);
            check("bcd_result", 32'(bus.o_bcd), 32'(e.bcd));
            check("ovf_result", 32'(bus.o_ovf), 32'(e.ovf));
            last_bcd = e.bcd;
            last_ovf = e.ovf;
        end else begin
            check("done_quiet", 32'(bus.o_done), 32'd0);
            check("bcd_hold", 32'(bus.o_bcd), 32'(last_bcd));
            check("ovf_hold", 32'(bus.o_ovf), 32'(last_ovf));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request; i_bin is scrambled right after the accepting edge.
    task automatic start_req(input int value);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_bin   = BIN_W'(value);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_bin   = BIN_W'($urandom_range(0, MAXV));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_bcd"},  32'(bus.o_bcd),  32'd0);
        check({tag, "_ovf"},  32'(bus.o_ovf),  32'd0);
    endtask

    function automatic int pick_value();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, MAXV));
            1:       v = int'($urandom_range(9990, 10009));
            2:       v = int'($urandom_range(0, 20));
            default: v = MAXV - int'($urandom_range(0, 20));
        endcase
        return v;
    endfunction

    initial begin
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_bin   = '0;
        wait_cycles(3);
        #1;
        check_all_zero("reset");

        // Release reset and request 0 in the same cycle.
        @(negedge clk);
        rst_n       = 1'b1;
        bus.i_start = 1'b1;
        bus.i_bin   = '0;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_cycles(15);

        // Chained through the o_done cycle, then the overflow boundaries.
        start_req(1234);
        wait_cycles(14);
        start_req(9999);
        wait_cycles(14);
        start_req(10000);
        wait_cycles(16);
        start_req(16383);
        wait_cycles(16);

        // i_start held high with i_bin changing every cycle.
        @(negedge clk);
        bus.i_start = 1'b1;
        repeat (64) begin
            bus.i_bin = BIN_W'($urandom_range(0, MAXV));
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        wait_cycles(18);

        // Request for 42 during SHIFT cycle 5 of a 777 conversion.
        start_req(777);
        wait_cycles(3);
        start_req(42);
        wait_cycles(16);

        // Reset during SHIFT cycle 7, then a request for 5.
        start_req(3210);
        wait_cycles(17);
        start_req(8765);
        wait_cycles(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        wait_cycles(2);
        rst_n       = 1'b1;
        bus.i_start = 1'b1;
        bus.i_bin   = BIN_W'(5);
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_cycles(17);

        // Random traffic: sparse requests, boundary-weighted values.
        repeat (400) begin
            @(negedge clk);
            bus.i_start = ($urandom_range(0, 3) == 0);
            bus.i_bin   = BIN_W'(pick_value());
        end
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_cycles(20);

        check("outstanding", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
